// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC sequencer: advances, holds, redirects (j > beq > jmem), flushes and halts
// the 20-bit MIPS program counter. Every output is taken straight from a register.
module fetch_pc_sequencer #(
  parameter logic [19:0] RESET_PC     = 20'h00000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_halt,
  input  logic        i_j,
  input  logic        i_beq,
  input  logic        i_jmem,
  input  logic [19:0] i_jump_value,
  input  logic [19:0] i_beq_value,
  input  logic [19:0] i_jmem_value,
  output logic [19:0] o_pc,
  output logic        o_fetch_valid,
  output logic        o_flush,
  output logic [1:0]  o_pc_src,
  output logic        o_halted,
  output logic        o_misalign_err
);

  localparam logic [2:0] LP_FLUSH_LOAD = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  function automatic logic is_misaligned(input logic [19:0] target);
    return (target[1:0] != 2'b00);
  endfunction

  state_t      r_state;
  logic [19:0] r_pc;
  logic        r_fetch_valid;
  logic        r_flush;
  logic [1:0]  r_pc_src;
  logic        r_halted;
  logic        r_misalign_err;
  logic [2:0]  r_flush_cnt;

  state_t      w_state_nxt;
  logic [19:0] w_pc_nxt;
  logic [1:0]  w_pc_src_nxt;
  logic [2:0]  w_flush_cnt_nxt;
  logic        w_misalign_nxt;
  logic        w_fetch_valid_nxt;
  logic        w_flush_nxt;
  logic        w_halted_nxt;
  logic        w_redirect;
  logic [19:0] w_target;
  logic [1:0]  w_src;

  // Fixed-priority redirect selection; losing targets are simply dropped.
  always_comb begin
    w_redirect = i_j | i_beq | i_jmem;
    w_target   = 20'h00000;
    w_src      = 2'b00;
    if (i_j) begin
      w_target = i_jump_value;
      w_src    = 2'b01;
    end else if (i_beq) begin
      w_target = i_beq_value;
      w_src    = 2'b10;
    end else if (i_jmem) begin
      w_target = i_jmem_value;
      w_src    = 2'b11;
    end else begin
      w_target = 20'h00000;
      w_src    = 2'b00;
    end
  end

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_pc_src_nxt    = r_pc_src;
    w_flush_cnt_nxt = r_flush_cnt;
    w_misalign_nxt  = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_redirect) begin
          w_pc_nxt        = {w_target[19:2], 2'b00};
          w_pc_src_nxt    = w_src;
          w_misalign_nxt  = is_misaligned(w_target);
          w_flush_cnt_nxt = LP_FLUSH_LOAD;
          w_state_nxt     = ST_FLUSH;
        end else if (i_halt) begin
          w_pc_src_nxt = 2'b00;
          w_state_nxt  = ST_HALT;
        end else if (i_stall || !r_fetch_valid) begin
          // The first RUN cycle after BOOT only raises fetch_valid at RESET_PC.
          w_pc_src_nxt = 2'b00;
        end else begin
          w_pc_nxt     = r_pc + 20'd4;
          w_pc_src_nxt = 2'b00;
        end
      end
      ST_FLUSH: begin
        if (w_redirect) begin
          w_pc_nxt        = {w_target[19:2], 2'b00};
          w_pc_src_nxt    = w_src;
          w_misalign_nxt  = is_misaligned(w_target);
          w_flush_cnt_nxt = LP_FLUSH_LOAD;
        end else if (r_flush_cnt <= 3'd1) begin
          w_flush_cnt_nxt = r_flush_cnt - ((r_flush_cnt != 3'd0) ? 3'd1 : 3'd0);
          w_state_nxt     = ST_RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 3'd1;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
    w_fetch_valid_nxt = (w_state_nxt == ST_RUN) && (r_state != ST_BOOT);
    w_flush_nxt       = (w_state_nxt == ST_FLUSH);
    w_halted_nxt      = (w_state_nxt == ST_HALT);
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_BOOT;
      r_pc           <= RESET_PC;
      r_fetch_valid  <= 1'b0;
      r_flush        <= 1'b0;
      r_pc_src       <= 2'b00;
      r_halted       <= 1'b0;
      r_misalign_err <= 1'b0;
      r_flush_cnt    <= 3'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_fetch_valid  <= w_fetch_valid_nxt;
      r_flush        <= w_flush_nxt;
      r_pc_src       <= w_pc_src_nxt;
      r_halted       <= w_halted_nxt;
      r_misalign_err <= w_misalign_nxt;
      r_flush_cnt    <= w_flush_cnt_nxt;
    end
  end

  assign o_pc           = r_pc;
  assign o_fetch_valid  = r_fetch_valid;
  assign o_flush        = r_flush;
  assign o_pc_src       = r_pc_src;
  assign o_halted       = r_halted;
  assign o_misalign_err = r_misalign_err;

endmodule
